preg_free_scheduler: RTL and testbench

Shares the freelist's two physical-register free ports (free1/free2 with addresses) between two requesters: squash reclaim, which is high priority, and retire reclaim, which is low priority. Each requester offers up to 2 pregs per cycle. Accepted pregs are packed into a circular FIFO. The FIFO drains up to 2 pregs per cycle onto registered free outputs wired to the freelist. The block sits between the commit/squash logic and the freelist, beside the rename stage.

---
 rtl/preg_free_scheduler.sv | 96 +++++++++
 tb/tb_preg_free_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/preg_free_scheduler.sv
// Arbitrates squash (high priority) and retire (low priority) preg reclaim into a FIFO feeding two freelist free ports.
// One cycle minimum from acceptance to free strobe; ready depends only on registered occupancy (sq needs 2 slots, rt needs 4).
module preg_free_scheduler #(
  parameter int NUM_PREGS  = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    sq_valid,
  input  logic [PW-1:0] sq_preg0,
  input  logic [PW-1:0] sq_preg1,
  output logic          sq_ready,
  input  logic [1:0]    rt_valid,
  input  logic [PW-1:0] rt_preg0,
  input  logic [PW-1:0] rt_preg1,
  output logic          rt_ready,
  output logic          free1,
  output logic [PW-1:0] free1_addr,
  output logic          free2,
  output logic [PW-1:0] free2_addr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          err_overflow
);

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] space;
  logic [3:0]    lane_vld;
  logic [3:0]    lane_rdy;
  logic [3:0]    lane_acc;
  logic [PW-1:0] lane_preg [4];
  logic [2:0]    lane_off [4];
  logic [2:0]    n_enq;
  logic [1:0]    n_deq;
  logic          bad_req;

  assign space    = CW'(FIFO_DEPTH) - count;
  assign sq_ready = reset && (space >= CW'(2));
  assign rt_ready = reset && (space >= CW'(4));

  // Lane order sq0, sq1, rt0, rt1 defines packing order into the FIFO.
  assign lane_vld     = {rt_valid, sq_valid};
  assign lane_rdy     = {{2{rt_ready}}, {2{sq_ready}}};
  assign lane_acc     = lane_vld & lane_rdy;
  assign bad_req      = |(lane_vld & ~lane_rdy);
  assign lane_preg[0] = sq_preg0;
  assign lane_preg[1] = sq_preg1;
  assign lane_preg[2] = rt_preg0;
  assign lane_preg[3] = rt_preg1;

  assign n_deq = (count >= CW'(2)) ? 2'd2 : count[1:0];
  assign empty = (count == '0) && !free1 && !free2;

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < 4; i++) begin
      lane_off[i] = n_enq;
      if (lane_acc[i]) n_enq = n_enq + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_acc[i]) mem[tail + AW'(lane_off[i])] <= lane_preg[i];
    end
  end

  // Dequeue reads pre-enqueue state, so a preg written this edge is never freed on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      free1        <= 1'b0;
      free2        <= 1'b0;
      free1_addr   <= '0;
      free2_addr   <= '0;
      err_overflow <= 1'b0;
    end else begin
      head  <= head + AW'(n_deq);
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_deq);
      free1 <= (n_deq != 2'd0);
      free2 <= (n_deq == 2'd2);
      if (n_deq != 2'd0) free1_addr <= mem[head];
      if (n_deq == 2'd2) free2_addr <= mem[head + AW'(1)];
      if (bad_req) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_preg_free_scheduler.sv
// Directed bench for preg_free_scheduler with hand-computed expectations (NUM_PREGS=64, FIFO_DEPTH=8).
module tb_preg_free_scheduler;
  localparam int PW = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    sq_valid;
  logic [PW-1:0] sq_preg0, sq_preg1;
  logic          sq_ready;
  logic [1:0]    rt_valid;
  logic [PW-1:0] rt_preg0, rt_preg1;
  logic          rt_ready;
  logic          free1, free2;
  logic [PW-1:0] free1_addr, free2_addr;
  logic [CW-1:0] count;
  logic          empty;
  logic          err_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preg_free_scheduler #(.NUM_PREGS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .sq_valid(sq_valid), .sq_preg0(sq_preg0), .sq_preg1(sq_preg1), .sq_ready(sq_ready),
    .rt_valid(rt_valid), .rt_preg0(rt_preg0), .rt_preg1(rt_preg1), .rt_ready(rt_ready),
    .free1(free1), .free1_addr(free1_addr), .free2(free2), .free2_addr(free2_addr),
    .count(count), .empty(empty), .err_overflow(err_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sv, input int s0, input int s1,
                       input logic [1:0] rv, input int r0, input int r1);
    sq_valid = sv; sq_preg0 = PW'(s0); sq_preg1 = PW'(s1);
    rt_valid = rv; rt_preg0 = PW'(r0); rt_preg1 = PW'(r1);
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_free(input string tag, input logic f1, input int a1, input logic f2, input int a2);
    chk({tag, "_free1"}, free1, f1);
    if (f1) chk({tag, "_addr1"}, free1_addr, a1);
    chk({tag, "_free2"}, free2, f2);
    if (f2) chk({tag, "_addr2"}, free2_addr, a2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_free1", free1, 0);
    chk("rst_free2", free2, 0);
    chk("rst_addr1", free1_addr, 0);
    chk("rst_addr2", free2_addr, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_sq_ready", sq_ready, 0);
    chk("rst_rt_ready", rt_ready, 0);
    chk("rst_empty", empty, 1);
    #9 reset = 1'b1;
    #1;
    chk("post_rst_sq_ready", sq_ready, 1);
    chk("post_rst_rt_ready", rt_ready, 1);

    // Single squash on lane 1
    drive(2'b10, 0, 17, 2'b00, 0, 0);
    step(); idle();
    chk("t1_count", count, 1);
    chk("t1_nofree", free1, 0);
    step();
    chk_free("t1_c1", 1, 17, 0, 0);
    chk("t1_c1_count", count, 0);
    step();
    chk("t1_c2_free1", free1, 0);
    chk("t1_c2_empty", empty, 1);
    chk("t1_c2_addr_hold", free1_addr, 17);

    // All four lanes at count 0
    drive(2'b11, 3, 4, 2'b11, 5, 6);
    step(); idle();
    chk("t2_count", count, 4);
    step();
    chk_free("t2_c1", 1, 3, 1, 4);
    step();
    chk_free("t2_c2", 1, 5, 1, 6);
    step();
    chk("t2_c3_empty", empty, 1);
    chk("t2_c3_free1", free1, 0);

    // Ready thresholds, packing across wrap, overflow at count 6
    chk("t3_c0_rt_ready", rt_ready, 1);
    drive(2'b00, 0, 0, 2'b11, 30, 31);
    step();
    chk("t3_c1_count", count, 2);
    chk("t3_c1_rt_ready", rt_ready, 1);
    drive(2'b11, 32, 33, 2'b01, 34, 0);
    step();
    chk("t3_c2_count", count, 3);
    chk_free("t3_c2", 1, 30, 1, 31);
    chk("t3_c2_rt_ready", rt_ready, 1);
    drive(2'b11, 35, 36, 2'b01, 37, 0);
    step();
    chk("t3_c3_count", count, 4);
    chk_free("t3_c3", 1, 32, 1, 33);
    chk("t3_c3_rt_ready", rt_ready, 1);
    chk("t3_c3_sq_ready", sq_ready, 1);
    drive(2'b11, 38, 39, 2'b11, 40, 41);
    step();
    chk("t3_c4_count", count, 6);
    chk_free("t3_c4", 1, 34, 1, 35);
    chk("t3_c4_rt_ready", rt_ready, 0);
    chk("t3_c4_sq_ready", sq_ready, 1);
    chk("t3_c4_err", err_overflow, 0);
    drive(2'b00, 0, 0, 2'b11, 50, 51);
    step(); idle();
    chk("t3_c5_err", err_overflow, 1);
    chk("t3_c5_count", count, 4);
    chk_free("t3_c5", 1, 36, 1, 37);
    step();
    chk("t3_c6_count", count, 2);
    chk_free("t3_c6", 1, 38, 1, 39);
    step();
    chk("t3_c7_count", count, 0);
    chk_free("t3_c7", 1, 40, 1, 41);
    step();
    chk_free("t3_c8", 0, 0, 0, 0);
    chk("t3_c8_empty", empty, 1);
    chk("t3_c8_err_sticky", err_overflow, 1);

    // Reset mid-traffic with count 5
    drive(2'b11, 60, 61, 2'b11, 62, 63);
    step();
    chk("t4_d1_count", count, 4);
    drive(2'b11, 64, 65, 2'b01, 66, 0);
    step();
    chk("t4_d2_count", count, 5);
    chk_free("t4_d2", 1, 60, 1, 61);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_count", count, 0);
    chk("t4_rst_free1", free1, 0);
    chk("t4_rst_free2", free2, 0);
    chk("t4_rst_addr1", free1_addr, 0);
    chk("t4_rst_addr2", free2_addr, 0);
    chk("t4_rst_err", err_overflow, 0);
    chk("t4_rst_sq_ready", sq_ready, 0);
    chk("t4_rst_rt_ready", rt_ready, 0);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("t4_rel_empty", empty, 1);
    chk("t4_rel_sq_ready", sq_ready, 1);
    step();
    chk("t4_r1_free1", free1, 0);
    chk("t4_r1_free2", free2, 0);
    chk("t4_r1_count", count, 0);
    step();
    chk("t4_r2_free1", free1, 0);
    chk("t4_r2_empty", empty, 1);
    chk("t4_r2_err", err_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
